// File: rtl/gf128_inverter_pkg.sv
// Shared types and helpers for the GF(2^128) inverter.
// Field polynomial, state encoding and GCM bit-order reversal.
package gf128_pkg;

  localparam logic [128:0] GF128_POLY = {1'b1, 120'h0, 8'h87};

  typedef logic [127:0] gf128_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } gfinv_state_e;

  function automatic gf128_t bitrev128(input gf128_t a);
    gf128_t r;
    for (int i = 0; i < 128; i++) begin
      r[i] = a[127-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf128_inverter_if.sv
// Operand/result handshake bundle for gf128_inverter.
// master = operand source / result sink, slave = inverter.
interface gf128_inverter_if;
  import gf128_pkg::*;

  logic   in_valid;
  logic   in_ready;
  gf128_t in_x;
  logic   out_valid;
  logic   out_ready;
  gf128_t out_z;
  logic   out_err;

  modport master (
    output in_valid,
    output in_x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_z,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_z,
    output out_err
  );

endinterface

// File: rtl/gf128_inverter_lead_one.sv
// 129-bit leading-one detector: returns the polynomial degree.
// A zero vector reports degree 0.
module gf128_lead_one (
  input  logic [128:0] i_vec,
  output logic [7:0]   o_deg
);

  always_comb begin
    o_deg = '0;
    for (int i = 0; i < 129; i++) begin
      if (i_vec[i]) o_deg = 8'(i);
    end
  end

endmodule

// File: rtl/gf128_inverter.sv
// Sequential GF(2^128) inverse by binary extended Euclid,
// one reduction step per cycle, with a watchdog on the busy phase.
module gf128_inverter
  import gf128_pkg::*;
#(
  parameter int MAX_CYCLES = 520
) (
  input  logic              clk,
  input  logic              rst_n,
  gf128_inverter_if.slave   bus
);

  gfinv_state_e r_state;
  gfinv_state_e w_next;

  gf128_t       r_x;
  logic [128:0] r_u;
  logic [128:0] r_v;
  logic [128:0] r_g1;
  logic [128:0] r_g2;
  logic [9:0]   r_cnt;
  gf128_t       r_z;
  logic         r_err;

  logic [7:0]   w_deg_u;
  logic [7:0]   w_deg_v;
  logic         w_u_one;
  logic         w_v_one;
  logic         w_wd;
  logic         w_fin;

  gf128_lead_one u_lead_u (
    .i_vec (r_u),
    .o_deg (w_deg_u)
  );

  gf128_lead_one u_lead_v (
    .i_vec (r_v),
    .o_deg (w_deg_v)
  );

  // Divide by x modulo f, keeping g*a == u (mod f).
  function automatic logic [128:0] halve(
    input logic [128:0] g
  );
    return g[0] ? ((g ^ GF128_POLY) >> 1) : (g >> 1);
  endfunction

  function automatic gf128_t reduce(
    input logic [128:0] g
  );
    logic [128:0] t;
    t = g[128] ? (g ^ GF128_POLY) : g;
    return t[127:0];
  endfunction

  assign w_u_one = (r_u == 129'd1);
  assign w_v_one = (r_v == 129'd1);
  assign w_wd    = (r_cnt == 10'(MAX_CYCLES));
  assign w_fin   = r_u[0] & r_v[0]
                 & (w_u_one | w_v_one);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.in_valid) w_next = LOAD;
      LOAD: w_next = (r_x == '0) ? DONE : RUN;
      RUN:  if (w_wd || w_fin) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_u   <= '0;
      r_v   <= '0;
      r_g1  <= '0;
      r_g2  <= '0;
      r_cnt <= '0;
      r_z   <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) r_x <= bus.in_x;
        end
        LOAD: begin
          r_u   <= {1'b0, bitrev128(r_x)};
          r_v   <= GF128_POLY;
          r_g1  <= 129'd1;
          r_g2  <= '0;
          r_cnt <= '0;
          r_z   <= '0;
          r_err <= (r_x == '0);
        end
        RUN: begin
          r_cnt <= r_cnt + 10'd1;
          if (w_wd) begin
            r_z   <= '0;
            r_err <= 1'b1;
          end else if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_g1 <= halve(r_g1);
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_g2 <= halve(r_g2);
          end else if (w_u_one) begin
            r_z <= bitrev128(reduce(r_g1));
          end else if (w_v_one) begin
            r_z <= bitrev128(reduce(r_g2));
          end else if (w_deg_u >= w_deg_v) begin
            r_u  <= r_u ^ r_v;
            r_g1 <= r_g1 ^ r_g2;
          end else begin
            r_v  <= r_v ^ r_u;
            r_g2 <= r_g2 ^ r_g1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_z   <= '0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_z     = r_z;
  assign bus.out_err   = r_err;

endmodule
